// File: rtl/montacargas_pkg.sv
// Shared constants for the Montacargas input conditioner: channel map and default timing.
// Also holds the helper used by the optional MONTACARGAS_LIMIT_FAULT_EN limit-switch check.
package montacargas_pkg;

   localparam int NUM_CH = 7;

   localparam int CH_P1  = 0;
   localparam int CH_P2  = 1;
   localparam int CH_P3  = 2;
   localparam int CH_SPC = 3;
   localparam int CH_FC1 = 4;
   localparam int CH_FC2 = 5;
   localparam int CH_FC3 = 6;

   localparam int DEFAULT_TICK_DIV       = 4000;
   localparam int DEFAULT_DEBOUNCE_TICKS = 20;

   // The cabin can only be at one floor, so two active limit switches means a wiring or sensor fault
   function automatic logic atLeastTwo(input logic [2:0] bits);
      return (bits[0] & bits[1]) | (bits[0] & bits[2]) | (bits[1] & bits[2]);
   endfunction

endpackage

// File: rtl/montacargas_debounce_ch.sv
// One input channel: 2-FF synchroniser followed by a tick-sampled debounce counter.
module montacargas_debounce_ch #(
   parameter int DEBOUNCE_TICKS = 20
) (
   input  logic clockBase_4MHz,
   input  logic reset,
   input  logic tick,
   input  logic raw,
   output logic level
);

   localparam int CW = $clog2(DEBOUNCE_TICKS + 1);
   localparam logic [CW-1:0] LAST_COUNT = CW'(DEBOUNCE_TICKS - 1);

   logic          syncMeta;
   logic          syncOut;
   logic [CW-1:0] debCount;

   // Any agreeing sample restarts the count; the >= compare keeps the counter from ever wrapping
   always_ff @(posedge clockBase_4MHz or negedge reset) begin
      if (!reset) begin
         syncMeta <= 1'b0;
         syncOut  <= 1'b0;
         debCount <= '0;
         level    <= 1'b0;
      end else begin
         syncMeta <= raw;
         syncOut  <= syncMeta;
         if (tick) begin
            if (syncOut == level) begin
               debCount <= '0;
            end else if (debCount >= LAST_COUNT) begin
               level    <= ~level;
               debCount <= '0;
            end else begin
               debCount <= debCount + 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/montacargas_input_conditioner.sv
// Front end for the Montacargas controller: sample tick, per-channel debounce, press strobes.
// Defining MONTACARGAS_LIMIT_FAULT_EN adds the sticky fc_fault output and pulse suppression.
module montacargas_input_conditioner
   import montacargas_pkg::*;
#(
   parameter int TICK_DIV       = DEFAULT_TICK_DIV,
   parameter int DEBOUNCE_TICKS = DEFAULT_DEBOUNCE_TICKS
) (
   input  logic       clockBase_4MHz,
   input  logic       reset,
   input  logic       BotonPiso1_raw,
   input  logic       BotonPiso2_raw,
   input  logic       BotonPiso3_raw,
   input  logic       SensorPuertaCerrada_raw,
   input  logic       FinalCarreraPiso1_raw,
   input  logic       FinalCarreraPiso2_raw,
   input  logic       FinalCarreraPiso3_raw,
   output logic [2:0] boton_lvl,
   output logic [2:0] boton_pulse,
   output logic       puerta_cerrada,
   output logic [2:0] final_carrera,
   output logic       tick_1ms
`ifdef MONTACARGAS_LIMIT_FAULT_EN
   ,
   output logic       fc_fault
`endif
);

   localparam int TW = $clog2(TICK_DIV);
   localparam logic [TW-1:0] LAST_TICK = TW'(TICK_DIV - 1);

   logic [TW-1:0]     tickCount;
   logic [NUM_CH-1:0] rawVec;
   logic [NUM_CH-1:0] levelVec;
   logic [2:0]        lvlPrev;
   logic [2:0]        pulseReg;
   logic [2:0]        pulseMask;

   // Free-running divider; the tick is decoded from the last count so it is high for one clock
   always_ff @(posedge clockBase_4MHz or negedge reset) begin
      if (!reset) begin
         tickCount <= '0;
      end else if (tickCount == LAST_TICK) begin
         tickCount <= '0;
      end else begin
         tickCount <= tickCount + 1'b1;
      end
   end

   assign tick_1ms = (tickCount == LAST_TICK);

   assign rawVec[CH_P1]  = BotonPiso1_raw;
   assign rawVec[CH_P2]  = BotonPiso2_raw;
   assign rawVec[CH_P3]  = BotonPiso3_raw;
   assign rawVec[CH_SPC] = SensorPuertaCerrada_raw;
   assign rawVec[CH_FC1] = FinalCarreraPiso1_raw;
   assign rawVec[CH_FC2] = FinalCarreraPiso2_raw;
   assign rawVec[CH_FC3] = FinalCarreraPiso3_raw;

   for (genvar g = 0; g < NUM_CH; g++) begin : gChannel
      montacargas_debounce_ch #(
         .DEBOUNCE_TICKS(DEBOUNCE_TICKS)
      ) uChannel (
         .clockBase_4MHz(clockBase_4MHz),
         .reset         (reset),
         .tick          (tick_1ms),
         .raw           (rawVec[g]),
         .level         (levelVec[g])
      );
   end

   assign boton_lvl      = {levelVec[CH_P3], levelVec[CH_P2], levelVec[CH_P1]};
   assign puerta_cerrada = levelVec[CH_SPC];
   assign final_carrera  = {levelVec[CH_FC3], levelVec[CH_FC2], levelVec[CH_FC1]};

`ifdef MONTACARGAS_LIMIT_FAULT_EN
   logic faultReg;

   // Once two limit switches agree the cabin is at two floors, stay latched until reset
   always_ff @(posedge clockBase_4MHz or negedge reset) begin
      if (!reset) begin
         faultReg <= 1'b0;
      end else begin
         faultReg <= faultReg | atLeastTwo(final_carrera);
      end
   end

   assign fc_fault  = faultReg;
   assign pulseMask = {3{~faultReg}};
`else
   assign pulseMask = 3'b111;
`endif

   // Rising-edge detect on the debounced levels; lvlPrev is cleared in reset so a held button cannot pulse early
   always_ff @(posedge clockBase_4MHz or negedge reset) begin
      if (!reset) begin
         lvlPrev  <= '0;
         pulseReg <= '0;
      end else begin
         lvlPrev  <= boton_lvl;
         pulseReg <= boton_lvl & ~lvlPrev & pulseMask;
      end
   end

   assign boton_pulse = pulseReg;

endmodule

// File: tb/tb_montacargas_input_conditioner.sv
// Directed bench for montacargas_input_conditioner with TICK_DIV=4, DEBOUNCE_TICKS=3.
// Build with MONTACARGAS_LIMIT_FAULT_EN defined to also exercise fc_fault.
module tb_montacargas_input_conditioner;

   logic       clock;
   logic       resetN;
   logic [6:0] rawState;
   logic [2:0] boton_lvl;
   logic [2:0] boton_pulse;
   logic       puerta_cerrada;
   logic [2:0] final_carrera;
   logic       tick_1ms;
`ifdef MONTACARGAS_LIMIT_FAULT_EN
   logic       fcFault;
`endif

   int checkCount;
   int errorCount;
   int pulseCount [3];
   int simulCount;
   int lvl1Cycles;

   montacargas_input_conditioner #(
      .TICK_DIV      (4),
      .DEBOUNCE_TICKS(3)
   ) dut (
      .clockBase_4MHz         (clock),
      .reset                  (resetN),
      .BotonPiso1_raw         (rawState[0]),
      .BotonPiso2_raw         (rawState[1]),
      .BotonPiso3_raw         (rawState[2]),
      .SensorPuertaCerrada_raw(rawState[3]),
      .FinalCarreraPiso1_raw  (rawState[4]),
      .FinalCarreraPiso2_raw  (rawState[5]),
      .FinalCarreraPiso3_raw  (rawState[6]),
      .boton_lvl              (boton_lvl),
      .boton_pulse            (boton_pulse),
      .puerta_cerrada         (puerta_cerrada),
      .final_carrera          (final_carrera),
      .tick_1ms               (tick_1ms)
`ifdef MONTACARGAS_LIMIT_FAULT_EN
      ,
      .fc_fault               (fcFault)
`endif
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Pulse activity is accumulated mid-cycle; checks compare against snapshots taken before each scenario
   initial begin
      pulseCount[0] = 0;
      pulseCount[1] = 0;
      pulseCount[2] = 0;
      simulCount    = 0;
      lvl1Cycles    = 0;
      forever begin
         @(negedge clock);
         if (resetN) begin
            for (int i = 0; i < 3; i++) pulseCount[i] += int'(boton_pulse[i]);
            if (boton_pulse == 3'b101) simulCount++;
            if (boton_lvl[1]) lvl1Cycles++;
         end
      end
   end

   task automatic applyStimulus(input logic [6:0] vec);
      rawState = vec;
   endtask

   task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
      checkCount++;
      assert (observed === expected) else begin
         errorCount++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic waitCycles(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   initial begin
      int base0;
      int base1;
      int base2;
      int baseSimul;
      int baseLvl1;
      logic found;

      checkCount = 0;
      errorCount = 0;
      resetN     = 1'b0;
      applyStimulus(7'b0001000);
      waitCycles(3);

      $display("[TB] reset state with door sensor held closed");
      checkOutput("rstBotonLvl", 8'(boton_lvl), 8'h0);
      checkOutput("rstBotonPulse", 8'(boton_pulse), 8'h0);
      checkOutput("rstPuerta", 8'(puerta_cerrada), 8'h0);
      checkOutput("rstFinalCarrera", 8'(final_carrera), 8'h0);
      checkOutput("rstTick", 8'(tick_1ms), 8'h0);
`ifdef MONTACARGAS_LIMIT_FAULT_EN
      checkOutput("rstFcFault", 8'(fcFault), 8'h0);
`endif

      resetN = 1'b1;
      waitCycles(3);
      checkOutput("tickFirst", 8'(tick_1ms), 8'h1);
      waitCycles(1);
      checkOutput("tickLowAfter", 8'(tick_1ms), 8'h0);
      waitCycles(2);
      checkOutput("tickLowBefore", 8'(tick_1ms), 8'h0);
      waitCycles(1);
      checkOutput("tickSecond", 8'(tick_1ms), 8'h1);
      waitCycles(4);
      checkOutput("tickThird", 8'(tick_1ms), 8'h1);
      checkOutput("puertaNotYet", 8'(puerta_cerrada), 8'h0);
      waitCycles(1);
      checkOutput("puertaRise", 8'(puerta_cerrada), 8'h1);

      $display("[TB] single press on floor 3");
      base2 = pulseCount[2];
      applyStimulus(7'b0001100);
      waitCycles(20);
      checkOutput("p3LvlHeld", 8'(boton_lvl), 8'h4);
      checkOutput("p3PulseOnce", 8'(pulseCount[2] - base2), 8'h1);
      applyStimulus(7'b0001000);
      waitCycles(2);
      checkOutput("p3LvlJustReleased", 8'(boton_lvl), 8'h4);
      waitCycles(18);
      checkOutput("p3LvlReleased", 8'(boton_lvl), 8'h0);
      checkOutput("p3NoReleasePulse", 8'(pulseCount[2] - base2), 8'h1);

      $display("[TB] bouncing floor 2 button");
      base1    = pulseCount[1];
      baseLvl1 = lvl1Cycles;
      applyStimulus(7'b0001010);
      waitCycles(8);
      applyStimulus(7'b0001000);
      waitCycles(4);
      applyStimulus(7'b0001010);
      waitCycles(8);
      applyStimulus(7'b0001000);
      waitCycles(16);
      checkOutput("bounceNoLvl", 8'(lvl1Cycles - baseLvl1), 8'h0);
      checkOutput("bounceNoPulse", 8'(pulseCount[1] - base1), 8'h0);

      $display("[TB] simultaneous floor 1 and floor 3 presses");
      base0     = pulseCount[0];
      base2     = pulseCount[2];
      baseSimul = simulCount;
      applyStimulus(7'b0001101);
      waitCycles(20);
      checkOutput("simulLvl", 8'(boton_lvl), 8'h5);
      checkOutput("simulPulse101", 8'(simulCount - baseSimul), 8'h1);
      checkOutput("simulP1Once", 8'(pulseCount[0] - base0), 8'h1);
      checkOutput("simulP3Once", 8'(pulseCount[2] - base2), 8'h1);
      applyStimulus(7'b0001000);
      waitCycles(20);
      checkOutput("simulReleased", 8'(boton_lvl), 8'h0);

      $display("[TB] limit switch 3 debounce");
      applyStimulus(7'b1001000);
      waitCycles(20);
      checkOutput("fc3Lvl", 8'(final_carrera), 8'h4);
      applyStimulus(7'b0001000);
      waitCycles(20);
      checkOutput("fc3Released", 8'(final_carrera), 8'h0);

      $display("[TB] reset pulse mid-debounce with floor 1 held");
      applyStimulus(7'b0001001);
      waitCycles(2);
      for (int t = 0; t < 2; t++) begin
         found = 1'b0;
         for (int k = 0; k < 10 && !found; k++) begin
            if (tick_1ms) found = 1'b1;
            else waitCycles(1);
         end
         checkOutput("tickWait", 8'(found), 8'h1);
         waitCycles(1);
      end
      checkOutput("midLvlStillLow", 8'(boton_lvl), 8'h0);
      resetN = 1'b0;
      waitCycles(2);
      checkOutput("midRstLvl", 8'(boton_lvl), 8'h0);
      checkOutput("midRstPulse", 8'(boton_pulse), 8'h0);
      base0  = pulseCount[0];
      resetN = 1'b1;
      waitCycles(2);
      checkOutput("midNoPulseRelease", 8'(pulseCount[0] - base0), 8'h0);
      waitCycles(9);
      checkOutput("midLvlBeforeDebounce", 8'(boton_lvl), 8'h0);
      checkOutput("midNoPulseEarly", 8'(pulseCount[0] - base0), 8'h0);
      waitCycles(1);
      checkOutput("midLvlAfterDebounce", 8'(boton_lvl), 8'h1);
      waitCycles(2);
      checkOutput("midOnePulse", 8'(pulseCount[0] - base0), 8'h1);
      applyStimulus(7'b0001000);
      waitCycles(20);

`ifdef MONTACARGAS_LIMIT_FAULT_EN
      $display("[TB] limit switch fault");
      applyStimulus(7'b0111000);
      waitCycles(20);
      checkOutput("faultFcLvl", 8'(final_carrera), 8'h3);
      checkOutput("faultSet", 8'(fcFault), 8'h1);
      applyStimulus(7'b0001000);
      waitCycles(20);
      checkOutput("faultFcCleared", 8'(final_carrera), 8'h0);
      checkOutput("faultSticky", 8'(fcFault), 8'h1);
      base1 = pulseCount[1];
      applyStimulus(7'b0001010);
      waitCycles(20);
      checkOutput("faultP2Lvl", 8'(boton_lvl), 8'h2);
      checkOutput("faultP2NoPulse", 8'(pulseCount[1] - base1), 8'h0);
      applyStimulus(7'b0001000);
      waitCycles(20);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
